// File: rtl/dac_playback_engine_pkg.sv
// Shared encodings for the DAC playback engine: FSM states, GPIO control/status
// field positions and the beat width helper.
package dac_playback_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_e;

    localparam int GI_LOAD   = 0;
    localparam int GI_CH_LO  = 1;
    localparam int GI_CH_HI  = 4;
    localparam int GI_START  = 5;
    localparam int GI_ABORT  = 6;
    localparam int GI_LOOP   = 7;
    localparam int GI_LEN_LO = 16;
    localparam int GI_LEN_HI = 31;

    localparam int GO_ST_LO  = 0;
    localparam int GO_ST_HI  = 1;
    localparam int GO_OVF    = 2;
    localparam int GO_BAD    = 3;
    localparam int GO_DONE   = 4;
    localparam int GO_CNT_LO = 16;
    localparam int GO_CNT_HI = 31;

    function automatic int beat_w(input int sample_w, input int spb);
        return sample_w * spb;
    endfunction

endpackage

// File: rtl/dac_playback_engine_beat_buffer_sdp.sv
// Simple dual-port beat buffer: one write port, registered read with enable so
// the read data holds while the consumer stalls.
module beat_buffer_sdp #(
    parameter int DEPTH  = 1024,
    parameter int W      = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dac_playback_engine.sv
// Multi-channel DAC playback engine: packs the 16-bit DMA stream into per-channel
// beat buffers and replays all channels in lockstep on AXI-Stream outputs.
module dac_playback_engine
    import dac_playback_engine_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int SAMPLE_W = 16,
    parameter int SPB      = 16,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [31:0]                      gpio_in,
    output logic [31:0]                      gpio_out_bus,
    input  logic [15:0]                      s_axis_tdata,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic [N_CH*SAMPLE_W*SPB-1:0]     m_axis_tdata,
    output logic [N_CH-1:0]                  m_axis_tvalid,
    input  logic [N_CH-1:0]                  m_axis_tready
);

    localparam int BW    = beat_w(SAMPLE_W, SPB);
    localparam int IDX_W = (SPB > 1) ? $clog2(SPB) : 1;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] MAX_A   = ADDR_W'(DEPTH - 1);

    state_e                         r_state, w_nstate;
    logic                           r_g_load, r_g_start, r_g_abort, r_g_loop;
    logic [3:0]                     r_g_ch, r_ch;
    logic [15:0]                    r_g_len;
    logic                           r_load_d, r_start_d;
    logic                           r_ovf, r_bad, r_done, r_loop, r_vld;
    logic [ADDR_W:0]                r_waddr;
    logic [ADDR_W-1:0]              r_raddr, r_len;
    logic [IDX_W-1:0]               r_idx;
    logic [SPB-1:0][SAMPLE_W-1:0]   r_pack;
    logic [SPB-1:0][SAMPLE_W-1:0]   w_beat;
    logic                           w_load_edge, w_start_edge, w_ch_ok;
    logic                           w_acc, w_wr, w_wr_ok, w_hs, w_last, w_stop, w_re;
    logic [ADDR_W-1:0]              w_next_addr, w_rd_addr, w_len_cap;
    logic [15:0]                    w_cnt16;
    logic                           w_unused;

    assign w_unused     = ^gpio_in[15:8];
    assign w_load_edge  = r_g_load & ~r_load_d;
    assign w_start_edge = r_g_start & ~r_start_d;
    assign w_ch_ok      = 32'(r_g_ch) < N_CH;
    assign w_len_cap    = (17'(r_g_len) > 17'(MAX_A)) ? MAX_A : ADDR_W'(r_g_len);

    assign w_acc   = (r_state == ST_LOAD) & s_axis_tvalid;
    assign w_wr    = w_acc & ((r_idx == IDX_W'(SPB - 1)) | s_axis_tlast);
    assign w_wr_ok = w_wr & (r_waddr < DEPTH_V);

    // A tlast word always lands in the beat it closes, so no empty beat is ever written.
    always_comb begin
        w_beat = '0;
        for (int j = 0; j < SPB; j++) begin
            if (j < int'(r_idx))       w_beat[j] = r_pack[j];
            else if (j == int'(r_idx)) w_beat[j] = SAMPLE_W'(s_axis_tdata);
        end
    end

    assign w_hs        = r_vld & (&m_axis_tready);
    assign w_last      = (r_raddr == r_len);
    assign w_stop      = w_hs & (r_g_abort | (w_last & ~r_loop));
    assign w_next_addr = w_last ? '0 : r_raddr + 1'b1;
    // Priming read on PLAY entry, then one read per accepted beat.
    assign w_re        = (r_state == ST_PLAY) & (~r_vld | (w_hs & ~w_stop));
    assign w_rd_addr   = r_vld ? w_next_addr : r_raddr;

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_load_edge && w_ch_ok) w_nstate = ST_LOAD;
                else if (w_start_edge && !w_load_edge) w_nstate = ST_PLAY;
            end
            ST_LOAD: if (w_acc && s_axis_tlast) w_nstate = ST_IDLE;
            ST_PLAY: if (w_stop) w_nstate = ST_IDLE;
            default: w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_nstate;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_g_load <= 1'b0; r_g_start <= 1'b0; r_g_abort <= 1'b0; r_g_loop <= 1'b0;
            r_g_ch <= '0; r_g_len <= '0; r_load_d <= 1'b0; r_start_d <= 1'b0;
            r_ch <= '0; r_ovf <= 1'b0; r_bad <= 1'b0; r_done <= 1'b0; r_loop <= 1'b0;
            r_vld <= 1'b0; r_waddr <= '0; r_raddr <= '0; r_len <= '0; r_idx <= '0;
            r_pack <= '0;
        end else begin
            r_g_load  <= gpio_in[GI_LOAD];
            r_g_ch    <= gpio_in[GI_CH_HI:GI_CH_LO];
            r_g_start <= gpio_in[GI_START];
            r_g_abort <= gpio_in[GI_ABORT];
            r_g_loop  <= gpio_in[GI_LOOP];
            r_g_len   <= gpio_in[GI_LEN_HI:GI_LEN_LO];
            r_load_d  <= r_g_load;
            r_start_d <= r_g_start;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_load_edge) begin
                        r_ovf <= 1'b0;
                        r_bad <= ~w_ch_ok;
                        if (w_ch_ok) begin
                            r_ch    <= r_g_ch;
                            r_waddr <= '0;
                            r_idx   <= '0;
                        end
                    end else if (w_start_edge) begin
                        r_len   <= w_len_cap;
                        r_loop  <= r_g_loop;
                        r_done  <= 1'b0;
                        r_raddr <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_acc) begin
                        r_pack[r_idx] <= SAMPLE_W'(s_axis_tdata);
                        r_idx         <= w_wr ? '0 : r_idx + 1'b1;
                        if (w_wr_ok)   r_waddr <= r_waddr + 1'b1;
                        else if (w_wr) r_ovf   <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_re) begin
                        r_vld <= 1'b1;
                        if (r_vld) r_raddr <= w_next_addr;
                    end
                    if (w_stop) begin
                        r_vld <= 1'b0;
                        if (!r_g_abort) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        beat_buffer_sdp #(.DEPTH(DEPTH), .W(BW), .ADDR_W(ADDR_W)) u_buf (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_wr_ok && (r_ch == 4'(k))),
            .i_waddr (r_waddr[ADDR_W-1:0]),
            .i_wdata (w_beat),
            .i_re    (w_re),
            .i_raddr (w_rd_addr),
            .o_rdata (m_axis_tdata[k*BW +: BW])
        );
    end

    assign w_cnt16       = (32'(r_waddr) > 32'h0000_FFFF) ? 16'hFFFF : 16'(r_waddr);
    assign s_axis_tready = (r_state == ST_LOAD);
    assign m_axis_tvalid = {N_CH{r_vld}};

    always_comb begin
        gpio_out_bus                      = '0;
        gpio_out_bus[GO_ST_HI:GO_ST_LO]   = r_state;
        gpio_out_bus[GO_OVF]              = r_ovf;
        gpio_out_bus[GO_BAD]              = r_bad;
        gpio_out_bus[GO_DONE]             = r_done;
        gpio_out_bus[GO_CNT_HI:GO_CNT_LO] = (r_state == ST_PLAY) ? 16'(r_raddr) : w_cnt16;
    end

endmodule

// File: tb/tb_dac_playback_engine.sv
// Bench for dac_playback_engine: table of loads with expected status, then play
// sequences checked against a model of the buffers through an expected-beat queue.
module tb_dac_playback_engine;

    localparam int N_CH = 3, SW = 16, SPB = 16, DEPTH = 4, BW = SW * SPB;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [31:0]          gpio_in = '0;
    logic [31:0]          gpio_out_bus;
    logic [15:0]          s_tdata = '0;
    logic                 s_tvalid = 1'b0, s_tlast = 1'b0;
    logic                 s_tready;
    logic [N_CH*BW-1:0]   m_tdata, held;
    logic [N_CH-1:0]      m_tvalid;
    logic [N_CH-1:0]      m_tready = '1;

    always #5 clk = ~clk;

    dac_playback_engine #(.N_CH(N_CH), .SAMPLE_W(SW), .SPB(SPB), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_in       (gpio_in),
        .gpio_out_bus  (gpio_out_bus),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    typedef struct {
        logic [N_CH*BW-1:0] data;
        logic [N_CH-1:0]    mask;
        int                 addr;
    } beat_t;

    typedef struct {
        int          ch;
        int          nwords;
        int          base;
        bit          with_start;
        logic [31:0] exp_status;
    } load_vec_t;

    beat_t           exp_q[$];
    logic [BW-1:0]   mem   [N_CH][DEPTH];
    bit              known [N_CH][DEPTH];
    load_vec_t       lv[4];
    int              n_vec = 0, n_err = 0, hs_cnt = 0;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are observed half a cycle before the edge that completes them.
    always @(negedge clk) begin
        beat_t e;
        if (rst && m_tvalid[0] && (&m_tready)) begin
            hs_cnt++;
            chk("tvalid_all", BW'(m_tvalid), BW'({N_CH{1'b1}}));
            if (exp_q.size() == 0) begin
                timeout("unexpected_beat");
            end else begin
                e = exp_q.pop_front();
                chk("play_addr", BW'(gpio_out_bus[31:16]), BW'(e.addr));
                for (int k = 0; k < N_CH; k++)
                    if (e.mask[k]) chk($sformatf("ch%0d_beat%0d", k, e.addr), m_tdata[k*BW +: BW], e.data[k*BW +: BW]);
            end
        end
    end

    task automatic push_play(input int len, input int n);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = i % (len + 1);
            e.data = '0;
            e.mask = '0;
            for (int k = 0; k < N_CH; k++) begin
                e.data[k*BW +: BW] = mem[k][e.addr];
                e.mask[k]          = known[k][e.addr];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic do_load(input int ch, input int n, input int base, input bit with_start);
        bit ok = 1'b0;
        gpio_in = 32'h1 | (32'(ch) << 1) | (with_start ? 32'h20 : 32'h0);
        for (int t = 0; t < 10; t++) begin
            tick();
            if (s_tready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            timeout("load_enter");
            gpio_in = '0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            s_tdata  = 16'(base + i);
            s_tvalid = 1'b1;
            s_tlast  = (i == n - 1);
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        gpio_in  = '0;
        for (int b = 0; b < DEPTH; b++) begin
            if (b * SPB < n) begin
                for (int s = 0; s < SPB; s++)
                    mem[ch][b][s*SW +: SW] = (b * SPB + s < n) ? 16'(base + b * SPB + s) : 16'h0;
                known[ch][b] = 1'b1;
            end
        end
        repeat (3) tick();
    endtask

    task automatic do_play(input int len_field, input bit loop_m);
        gpio_in = (32'(len_field) << 16) | (loop_m ? 32'h80 : 32'h0) | 32'h20;
        tick();
        tick();
        gpio_in = gpio_in & ~32'h20;
    endtask

    task automatic wait_done(input int limit);
        for (int t = 0; t < limit; t++) begin
            if (gpio_out_bus[4] && gpio_out_bus[1:0] == 2'd0) return;
            tick();
        end
        timeout("wait_done");
    endtask

    task automatic wait_hs(input int n, input int limit);
        int base = hs_cnt;
        for (int t = 0; t < limit; t++) begin
            tick();
            if (hs_cnt - base >= n) return;
        end
        timeout("wait_handshake");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lv[0] = '{ch: 1, nwords: 32, base: 'h000, with_start: 1'b0, exp_status: 32'h0002_0000};
        lv[1] = '{ch: 0, nwords: 20, base: 'h100, with_start: 1'b0, exp_status: 32'h0002_0000};
        lv[2] = '{ch: 2, nwords: 64, base: 'h200, with_start: 1'b1, exp_status: 32'h0004_0000};
        lv[3] = '{ch: 2, nwords: 96, base: 'h300, with_start: 1'b0, exp_status: 32'h0004_0004};

        repeat (3) tick();
        chk("rst_status", BW'(gpio_out_bus), '0);
        chk("rst_tvalid", BW'(m_tvalid), '0);
        chk("rst_tdata_zero", BW'(|m_tdata), '0);
        chk("rst_s_tready", BW'(s_tready), '0);
        rst = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            do_load(lv[i].ch, lv[i].nwords, lv[i].base, lv[i].with_start);
            chk($sformatf("load%0d_status", i), BW'(gpio_out_bus), BW'(lv[i].exp_status));
        end

        // One-shot, two beats, all consumers ready.
        push_play(1, 2);
        do_play(1, 1'b0);
        wait_done(50);
        chk("oneshot_status", BW'(gpio_out_bus), BW'(32'h0004_0014));
        chk("oneshot_tvalid_low", BW'(m_tvalid), '0);
        chk("oneshot_q_empty", BW'(exp_q.size()), '0);

        // Stall one consumer for 5 cycles mid-stream.
        push_play(3, 4);
        do_play(3, 1'b0);
        wait_hs(2, 50);
        m_tready = 3'b011;
        held = m_tdata;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("stall_tvalid", BW'(m_tvalid), BW'(3'b111));
            chk("stall_hold", BW'(m_tdata === held), BW'(1'b1));
        end
        m_tready = '1;
        wait_done(50);
        chk("stall_q_empty", BW'(exp_q.size()), '0);

        // Loop mode, 4 beats, abort on the 10th handshake.
        push_play(3, 10);
        do_play(3, 1'b1);
        wait_hs(9, 60);
        m_tready = '0;
        gpio_in  = gpio_in | 32'h40;
        repeat (3) tick();
        m_tready = '1;
        wait_hs(1, 10);
        chk("abort_tvalid_low", BW'(m_tvalid), '0);
        chk("abort_status", BW'(gpio_out_bus), BW'(32'h0004_0004));
        chk("abort_q_empty", BW'(exp_q.size()), '0);
        gpio_in = '0;
        repeat (2) tick();

        // Play length beyond the buffer is capped to DEPTH-1.
        push_play(3, 4);
        do_play(16'hFFFF, 1'b0);
        wait_done(50);
        chk("cap_status", BW'(gpio_out_bus), BW'(32'h0004_0014));
        chk("cap_q_empty", BW'(exp_q.size()), '0);

        // Load edge on a channel that does not exist.
        gpio_in = 32'h1 | (32'd5 << 1);
        repeat (3) tick();
        chk("badch_status", BW'(gpio_out_bus), BW'(32'h0004_0018));
        chk("badch_s_tready", BW'(s_tready), '0);
        gpio_in = '0;
        repeat (2) tick();

        // Reset in the middle of a looping play.
        push_play(1, 100);
        do_play(1, 1'b1);
        wait_hs(3, 50);
        rst = 1'b0;
        #1;
        chk("midrst_tvalid", BW'(m_tvalid), '0);
        chk("midrst_status", BW'(gpio_out_bus), '0);
        chk("midrst_tdata_zero", BW'(|m_tdata), '0);
        exp_q.delete();
        gpio_in = '0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("postrst_status", BW'(gpio_out_bus), '0);
        push_play(1, 2);
        do_play(1, 1'b0);
        wait_done(50);
        chk("replay_status", BW'(gpio_out_bus), BW'(32'h0000_0010));
        chk("replay_q_empty", BW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
